// File: rtl/layer_serializer.sv
// Gathers one word per neuron from a fully-connected layer, then streams the
// words one per cycle in neuron-index order into the next layer's input.
module layer_serializer #(
  parameter int neurons   = 10,
  parameter int dataWidth = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [neurons-1:0]             in_valid,
  input  logic [neurons*dataWidth-1:0]   in_data,
  output logic                           out_valid,
  output logic [dataWidth-1:0]           out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           overrun
);

  localparam int IDX_W = $clog2(neurons);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(neurons - 1);

  typedef enum logic {COLLECT, SEND} state_t;

  state_t                 state_reg, state_next;
  logic [neurons-1:0]     mask_reg, mask_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic                   out_valid_reg, out_valid_next;
  logic [dataWidth-1:0]   out_data_reg, out_data_next;
  logic                   out_last_reg, out_last_next;
  logic                   overrun_reg, overrun_next;

  logic [dataWidth-1:0]   in_word [neurons];
  logic [dataWidth-1:0]   word_buf_reg [neurons];
  logic [neurons-1:0]     merged_mask;

  for (genvar gi = 0; gi < neurons; gi++) begin : g_unpack
    assign in_word[gi] = in_data[gi*dataWidth +: dataWidth];
  end

  // Word storage needs no reset: it is only read after every slot was rewritten.
  always_ff @(posedge clk) begin
    if (state_reg == COLLECT) begin
      for (int i = 0; i < neurons; i++) begin
        if (in_valid[i]) word_buf_reg[i] <= in_word[i];
      end
    end
  end

  assign merged_mask = mask_reg | in_valid;

  always_comb begin
    state_next     = state_reg;
    mask_next      = mask_reg;
    idx_next       = idx_reg;
    out_valid_next = 1'b0;
    out_data_next  = out_data_reg;
    out_last_next  = 1'b0;
    overrun_next   = 1'b0;
    case (state_reg)
      COLLECT: begin
        mask_next = merged_mask;
        if (&merged_mask) begin
          state_next = SEND;
          idx_next   = '0;
          mask_next  = '0;
        end
      end
      SEND: begin
        out_valid_next = 1'b1;
        out_data_next  = word_buf_reg[idx_reg];
        out_last_next  = (idx_reg == LAST_IDX);
        // Inputs arriving while streaming are dropped, including on the final edge.
        overrun_next   = |in_valid;
        if (idx_reg == LAST_IDX) begin
          state_next = COLLECT;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= COLLECT;
      mask_reg      <= '0;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mask_reg      <= mask_next;
      idx_reg       <= idx_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg == SEND);
  assign overrun   = overrun_reg;

endmodule
